// File: rtl/abs_cmd_ctrl.sv
// Abstract-command sequencer: owns command/data0 and abstractcs busy/cmderr,
// validates command writes, issues cmd_update and waits (with timeout) for completion.
module abs_cmd_ctrl #(
    parameter int unsigned DM_REG_WIDTH   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rstn,
    input  logic                    cmd_wr,
    input  logic [DM_REG_WIDTH-1:0] cmd_wdata,
    input  logic                    data0_wr,
    input  logic [DM_REG_WIDTH-1:0] data0_wdata,
    input  logic                    abstractcs_wr,
    input  logic [DM_REG_WIDTH-1:0] abstractcs_wdata,
    input  logic                    halted,
    input  logic                    cmd_finished,
    input  logic [DM_REG_WIDTH-1:0] cmd_read_data,
    output logic [DM_REG_WIDTH-1:0] command,
    output logic [DM_REG_WIDTH-1:0] data0,
    output logic                    cmd_update,
    output logic                    busy,
    output logic [2:0]              cmderr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BUSY    = 3'd1;
    localparam logic [2:0] ERR_NOTSUP  = 3'd2;
    localparam logic [2:0] ERR_EXCEPT  = 3'd3;
    localparam logic [2:0] ERR_HALTRES = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Decode of the incoming command word
    logic [7:0] cmdtype;
    logic [2:0] aarsize;
    logic       transfer;
    logic       any_wr;
    logic       cmd_unsupported;
    logic       unused_wdata;

    assign cmdtype         = cmd_wdata[31:24];
    assign aarsize         = cmd_wdata[22:20];
    assign transfer        = cmd_wdata[17];
    assign any_wr          = cmd_wr | data0_wr | abstractcs_wr;
    assign cmd_unsupported = (cmdtype != 8'd0) || (transfer && (aarsize != 3'd2));
    assign unused_wdata    = ^{abstractcs_wdata[DM_REG_WIDTH-1:11], abstractcs_wdata[7:0]};

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            command    <= '0;
            data0      <= '0;
            cmd_update <= 1'b0;
            busy       <= 1'b0;
            cmderr     <= ERR_NONE;
        end else begin
            cmd_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (data0_wr) begin
                        data0 <= data0_wdata;
                    end
                    if (abstractcs_wr) begin
                        cmderr <= cmderr & ~abstractcs_wdata[10:8];
                    end
                    // A pending error blocks new commands until software clears it
                    if (cmd_wr && (cmderr == ERR_NONE)) begin
                        command <= cmd_wdata;
                        if (cmd_unsupported) begin
                            cmderr <= ERR_NOTSUP;
                        end else if (!halted) begin
                            cmderr <= ERR_HALTRES;
                        end else if (transfer) begin
                            state      <= ISSUE;
                            cmd_update <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (any_wr && (cmderr == ERR_NONE)) begin
                        cmderr <= ERR_BUSY;
                    end
                    if (cmd_finished) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!command[16]) begin
                            data0 <= cmd_read_data;
                        end
                    end else begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end

                WAIT: begin
                    if (any_wr && (cmderr == ERR_NONE)) begin
                        cmderr <= ERR_BUSY;
                    end
                    // Completion takes priority over a coincident timeout
                    if (cmd_finished) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!command[16]) begin
                            data0 <= cmd_read_data;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        cmderr <= ERR_EXCEPT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abs_cmd_ctrl.sv
// Self-checking bench for abs_cmd_ctrl: transaction-level model compared every cycle,
// plus directed literal checks on the test-plan scenarios.
module tb_abs_cmd_ctrl;

    localparam int unsigned W   = 32;
    localparam int          TMO = 64;

    logic         sys_clk;
    logic         sys_rstn;
    logic         cmd_wr;
    logic [W-1:0] cmd_wdata;
    logic         data0_wr;
    logic [W-1:0] data0_wdata;
    logic         abstractcs_wr;
    logic [W-1:0] abstractcs_wdata;
    logic         halted;
    logic         cmd_finished;
    logic [W-1:0] cmd_read_data;
    logic [W-1:0] command;
    logic [W-1:0] data0;
    logic         cmd_update;
    logic         busy;
    logic [2:0]   cmderr;

    abs_cmd_ctrl #(.DM_REG_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk          (sys_clk),
        .sys_rstn         (sys_rstn),
        .cmd_wr           (cmd_wr),
        .cmd_wdata        (cmd_wdata),
        .data0_wr         (data0_wr),
        .data0_wdata      (data0_wdata),
        .abstractcs_wr    (abstractcs_wr),
        .abstractcs_wdata (abstractcs_wdata),
        .halted           (halted),
        .cmd_finished     (cmd_finished),
        .cmd_read_data    (cmd_read_data),
        .command          (command),
        .data0            (data0),
        .cmd_update       (cmd_update),
        .busy             (busy),
        .cmderr           (cmderr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy is an "access in flight" flag with an age
    // measured in busy cycles; timeout once the access has been busy TMO+1 cycles.
    logic [31:0] m_cmd   = '0;
    logic [31:0] m_data0 = '0;
    logic [2:0]  m_err   = '0;
    logic        m_busy  = 1'b0;
    logic        m_upd   = 1'b0;
    int          m_age   = 0;

    always @(posedge sys_clk or negedge sys_rstn) begin : model
        logic [31:0] c;
        logic [31:0] d;
        logic [2:0]  e;
        logic        b;
        logic        u;
        int          a;
        if (!sys_rstn) begin
            m_cmd   <= '0;
            m_data0 <= '0;
            m_err   <= '0;
            m_busy  <= 1'b0;
            m_upd   <= 1'b0;
            m_age   <= 0;
        end else begin
            c = m_cmd; d = m_data0; e = m_err; b = m_busy; a = m_age; u = 1'b0;
            if (b) begin
                if ((cmd_wr || data0_wr || abstractcs_wr) && e == 3'd0) e = 3'd1;
                if (cmd_finished) begin
                    b = 1'b0;
                    if (!c[16]) d = cmd_read_data;
                end else if (a == TMO) begin
                    b = 1'b0;
                    e = 3'd3;
                end else begin
                    a = a + 1;
                end
            end else begin
                if (data0_wr) d = data0_wdata;
                if (cmd_wr && e == 3'd0) begin
                    c = cmd_wdata;
                    if (c[31:24] != 8'd0 || (c[17] && c[22:20] != 3'd2)) e = 3'd2;
                    else if (!halted) e = 3'd4;
                    else if (c[17]) begin b = 1'b1; u = 1'b1; a = 0; end
                end
                if (abstractcs_wr) e = e & ~abstractcs_wdata[10:8];
            end
            m_cmd <= c; m_data0 <= d; m_err <= e; m_busy <= b; m_upd <= u; m_age <= a;
        end
    end

    // Per-cycle compare plus busy-run and pulse trackers
    int run_len  = 0;
    int last_run = 0;
    int upd_cnt  = 0;

    always @(negedge sys_clk) begin
        check("command", command, m_cmd);
        check("data0", data0, m_data0);
        check("cmd_update", 32'(cmd_update), 32'(m_upd));
        check("busy", 32'(busy), 32'(m_busy));
        check("cmderr", 32'(cmderr), 32'(m_err));
        if (!sys_rstn) begin
            run_len = 0;
        end else if (busy) begin
            run_len++;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (sys_rstn && cmd_update) upd_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic settle();
        @(negedge sys_clk);
        #1;
    endtask

    // Issue a command; k<0 means cmd_finished is never raised
    task automatic issue(input logic [31:0] cmd, input int k, input logic [31:0] rd);
        @(negedge sys_clk);
        cmd_wr = 1'b1; cmd_wdata = cmd;
        @(negedge sys_clk);
        cmd_wr = 1'b0;
        if (k >= 0) begin
            cyc(k);
            cmd_finished = 1'b1; cmd_read_data = rd;
            @(negedge sys_clk);
            cmd_finished = 1'b0;
        end
    endtask

    task automatic clear_err();
        @(negedge sys_clk);
        abstractcs_wr = 1'b1; abstractcs_wdata = 32'h0000_0700;
        @(negedge sys_clk);
        abstractcs_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    int pulses;

    initial begin
        cmd_wr = 0; cmd_wdata = 0; data0_wr = 0; data0_wdata = 0;
        abstractcs_wr = 0; abstractcs_wdata = 0; halted = 1'b1;
        cmd_finished = 0; cmd_read_data = 0;
        sys_rstn = 1'b1;
        #1 sys_rstn = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmderr", 32'(cmderr), 32'd0);
        check("rst_data0", data0, 32'd0);
        cyc(2);
        sys_rstn = 1'b1;
        cyc(2);

        // Write access finishing in the issue cycle
        issue(32'h0023_1300, 0, 32'h0);
        settle();
        check("wr_busy_len", 32'(last_run), 32'd1);
        check("wr_pulses", 32'(upd_cnt), 32'd1);
        check("wr_cmderr", 32'(cmderr), 32'd0);
        check("wr_command", command, 32'h0023_1300);

        // Read finishing 3 cycles after cmd_update
        issue(32'h0022_1300, 3, 32'hDEAD_BEEF);
        settle();
        check("rd_data0", data0, 32'hDEAD_BEEF);
        check("rd_busy_len", 32'(last_run), 32'd4);
        check("rd_pulses", 32'(upd_cnt), 32'd2);

        // Unsupported cmdtype, then W1C clear
        issue(32'h0100_0000, -1, 32'h0);
        settle();
        check("cmdtype_err", 32'(cmderr), 32'd2);
        check("cmdtype_nopulse", 32'(upd_cnt), 32'd2);
        clear_err();
        settle();
        check("w1c_clear", 32'(cmderr), 32'd0);

        // Bad aarsize with transfer
        issue(32'h0032_0000, -1, 32'h0);
        settle();
        check("aarsize_err", 32'(cmderr), 32'd2);
        clear_err();

        // transfer=0 is a no-op
        issue(32'h0020_0000, -1, 32'h0);
        settle();
        check("noop_err", 32'(cmderr), 32'd0);
        check("noop_nopulse", 32'(upd_cnt), 32'd2);
        check("noop_command", command, 32'h0020_0000);

        // Not halted, then a blocked command write
        halted = 1'b0;
        issue(32'h0022_1300, -1, 32'h0);
        settle();
        check("halt_err", 32'(cmderr), 32'd4);
        halted = 1'b1;
        issue(32'h0023_1234, -1, 32'h0);
        settle();
        check("blocked_command", command, 32'h0022_1300);
        check("blocked_nopulse", 32'(upd_cnt), 32'd2);
        check("blocked_err", 32'(cmderr), 32'd4);
        clear_err();

        // Timeout
        issue(32'h0022_1300, -1, 32'h0);
        wait_idle(200);
        settle();
        check("tmo_busy_len", 32'(last_run), 32'(TMO + 1));
        check("tmo_err", 32'(cmderr), 32'd3);
        check("tmo_data0", data0, 32'hDEAD_BEEF);
        clear_err();

        // Writes while busy are ignored and flag cmderr=1
        pulses = upd_cnt;
        issue(32'h0022_1300, -1, 32'h0);
        cyc(2);
        data0_wr = 1'b1; data0_wdata = 32'h0000_1234;
        @(negedge sys_clk);
        data0_wr = 1'b0;
        cmd_wr = 1'b1; cmd_wdata = 32'h0023_1300;
        @(negedge sys_clk);
        cmd_wr = 1'b0;
        #1;
        check("busywr_data0", data0, 32'hDEAD_BEEF);
        check("busywr_err", 32'(cmderr), 32'd1);
        check("busywr_command", command, 32'h0022_1300);
        cmd_finished = 1'b1; cmd_read_data = 32'hCAFE_0001;
        @(negedge sys_clk);
        cmd_finished = 1'b0;
        settle();
        check("busywr_capture", data0, 32'hCAFE_0001);
        check("busywr_pulses", 32'(upd_cnt), 32'(pulses + 1));
        clear_err();

        // cmd_wr in the last busy cycle counts as busy
        @(negedge sys_clk);
        cmd_wr = 1'b1; cmd_wdata = 32'h0023_1300;
        @(negedge sys_clk);
        cmd_finished = 1'b1; cmd_wdata = 32'h0023_0005;
        @(negedge sys_clk);
        cmd_wr = 1'b0; cmd_finished = 1'b0;
        #1;
        check("lastcyc_err", 32'(cmderr), 32'd1);
        check("lastcyc_busy", 32'(busy), 32'd0);
        check("lastcyc_command", command, 32'h0023_1300);
        clear_err();

        // Reset mid-WAIT
        issue(32'h0022_1300, -1, 32'h0);
        cyc(3);
        sys_rstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_command", command, 32'd0);
        check("midrst_data0", data0, 32'd0);
        check("midrst_err", 32'(cmderr), 32'd0);
        check("midrst_upd", 32'(cmd_update), 32'd0);
        cyc(2);
        sys_rstn = 1'b1;
        cyc(3);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/abs_cmd_ctrl.md
# abs_cmd_ctrl

Abstract-command sequencer in the debug module, between the DMI-facing register decode and `abs_cmd`. It owns the `command` and `data0` registers and the `abstractcs.busy`/`cmderr` state. It validates each command write and issues a one-cycle `cmd_update` to `abs_cmd`. It then waits, under a timeout, for `cmd_finished` and captures register-read results into `data0`.

## Interface
- `DM_REG_WIDTH`, default 32: width of the DM registers.
- `TIMEOUT_CYCLES`, default 64: maximum WAIT-state cycles before an access is declared failed. Must be ≥ 2.

Ports:
- `sys_clk` in 1: the single clock.
- `sys_rstn` in 1: reset, asynchronous and active-low.
- `cmd_wr` in 1: one-cycle strobe, DMI write to `command`.
- `cmd_wdata` in DM_REG_WIDTH: write value for `command`.
- `data0_wr` in 1: one-cycle strobe, DMI write to `data0`.
- `data0_wdata` in DM_REG_WIDTH: write value for `data0`.
- `abstractcs_wr` in 1: one-cycle strobe, DMI write to `abstractcs`.
- `abstractcs_wdata` in DM_REG_WIDTH: bits [10:8] are the W1C `cmderr` clear mask.
- `halted` in 1: hart is halted.
- `cmd_finished` in 1: access complete, from `abs_cmd`.
- `cmd_read_data` in DM_REG_WIDTH: read result, from `abs_cmd`.
- `command` out DM_REG_WIDTH: latched command, to `abs_cmd`.
- `data0` out DM_REG_WIDTH: data0 register, to `abs_cmd` and DMI read-back.
- `cmd_update` out 1: one-cycle issue pulse, to `abs_cmd`.
- `busy` out 1: `abstractcs.busy`.
- `cmderr` out 3: `abstractcs.cmderr`.

## Operation
- Command fields: `cmdtype` [31:24], `aarsize` [22:20], `transfer` [17], `write` [16], `regno` [15:0].
- States: IDLE, ISSUE, WAIT.
- **IDLE, `cmd_wr`, `cmderr`≠0:** write ignored; `command` unchanged.
- **IDLE, `cmd_wr`, `cmderr`=0:** latch `command`, then check in this priority order:
  - `cmdtype`≠0 → `cmderr`=2, stay IDLE.
  - `transfer`=1 and `aarsize`≠2 → `cmderr`=2, stay IDLE.
  - `halted`=0 → `cmderr`=4, stay IDLE.
  - `transfer`=0 → no-op, stay IDLE, no `cmd_update`.
  - Otherwise → ISSUE.
- **ISSUE:**
  - `cmd_update`=1 and `busy`=1.
  - If `cmd_finished` is high this cycle → IDLE; a read (`write`=0) loads `data0` from `cmd_read_data`.
  - Otherwise → WAIT with the timeout counter cleared.
- **WAIT:**
  - Counter increments each cycle.
  - `cmd_finished` → IDLE, capturing `data0` on a read.
  - Counter = TIMEOUT_CYCLES-1 with no `cmd_finished` → `cmderr`=3, IDLE, `data0` unchanged.
  - `cmd_finished` and timeout in the same cycle: `cmd_finished` wins.
- **While `busy`** (ISSUE/WAIT), any `cmd_wr`, `data0_wr` or `abstractcs_wr`:
  - The write is ignored.
  - If `cmderr` is 0 it is set to 1; a nonzero `cmderr` is not overwritten.
- **In IDLE:**
  - `data0_wr` loads `data0`.
  - `abstractcs_wr` clears the `cmderr` bits set in the mask: `cmderr` <= `cmderr` & ~`wdata`[10:8].
- Only one error source is possible per cycle; an error-set always lands in a cycle with no W1C clear.
- Timeout counter width is clog2(TIMEOUT_CYCLES); it is cleared on every entry to WAIT.

## Timing
- Reset state (async, immediate): state=IDLE; `command`=0, `data0`=0, `cmd_update`=0, `busy`=0, `cmderr`=0; counter=0.
- Reset asserted mid-access aborts it: no `data0` capture, no error recorded.
- All outputs are registered or decoded from state.
  - `cmd_update` and `busy` rise the cycle after the accepted `cmd_wr`.
  - `cmd_update` is high for exactly one cycle per issued command.
- Write access: `abs_cmd` finishes combinationally, so `busy` is high exactly 1 cycle.
- Read whose `cmd_finished` arrives k cycles after `cmd_update` (k≥1):
  - `busy` is high k+1 cycles.
  - `data0` updates at the clock edge that samples `cmd_finished`.
  - `busy` falls at that same edge.
- Validation errors set `cmderr` one cycle after `cmd_wr`; `busy` never rises.
- Timeout: `busy` is high 1+TIMEOUT_CYCLES cycles, then `cmderr`=3 and `busy`=0 at the same edge.
- A `cmd_wr` in the cycle `busy` falls is seen as busy (`cmderr`=1). The next cycle is IDLE.

## Test plan
- Halted, write 0x0023_1300 (write, aarsize=2, regno 0x1300), `cmd_finished` same cycle as `cmd_update` → one `cmd_update` pulse, `busy` 1 cycle, `cmderr`=0.
- Halted, write 0x0022_1300 (read), `cmd_finished` 3 cycles after `cmd_update` with `cmd_read_data`=0xDEAD_BEEF → `data0`=0xDEAD_BEEF, `busy` 4 cycles.
- `cmdtype`=1 → `cmderr`=2, no `cmd_update`. Then `abstractcs_wr` with mask 0x700 → `cmderr`=0.
- `halted`=0 with a valid read → `cmderr`=4. With `cmderr`≠0, a further `cmd_wr` is ignored (`command` unchanged, no pulse).
- Read with `cmd_finished` never asserted, TIMEOUT_CYCLES=64 → `busy` falls after 65 cycles, `cmderr`=3, `data0` unchanged.
- During WAIT, write `data0`=0x1234 and `cmd_wr` → `data0` unchanged, `cmderr`=1. Separately, `sys_rstn` low mid-WAIT → all outputs 0 immediately.
